// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
//   Shared constants for the SPI flash responder: FSM state encodings,
//   accepted opcodes, counter widths and a small bit-select helper.
// -----------------------------------------------------------------------------
package spi_flash_pkg;

    // FSM state encodings (plain constants so legacy tools can consume them)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DUMMY  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    // One counter covers the 8 opcode bits, up to 32 address bits,
    // 8 dummy cycles and the 32 bit positions of a data word.
    localparam int BIT_CNT_W = 5;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    // Bit 'idx' counted from the MSB: position 0 is word[31].
    function automatic logic word_bit(input logic [31:0] word, input bit_cnt_t idx);
        return word[~idx];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   STAGES-flop synchronizer for one asynchronous pin followed by an edge
//   detector. rise_o / fall_o are registered one-cycle pulses, so a pin edge
//   shows up as a pulse STAGES+1 clock cycles later.
// Ports
//   clock   in  system clock
//   resetn  in  asynchronous active-low reset (chain reset to RESET_VAL)
//   d_i     in  asynchronous pin
//   rise_o  out one-cycle pulse on a synchronized 0->1 transition
//   fall_o  out one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
//   SPI mode-0 flash stand-in. Decodes READ (opcode + 24-bit address, MSB
//   first) and streams 32-bit words fetched from a backing-memory port on
//   miso for as long as ss stays low. All SPI pins are oversampled by clock,
//   which must run at least 4x sck.
//   Build option: define FAST_READ_EN to also accept 0x0B (FAST READ) with
//   8 dummy sck cycles between the address and the data.
// Ports
//   clock, resetn     system clock, asynchronous active-low reset
//   spi_sck/ss/mosi   SPI inputs from the master (sck idles low, ss active low)
//   spi_miso          SPI output, 1 whenever no data bit is being driven
//   mem_req/mem_addr  word read request and byte address ([1:0] always 0)
//   mem_ack/mem_rdata one-cycle completion strobe with its data word
//   underrun          sticky: a word had to start before its data arrived
//   busy              ss low and a command is being handled
// -----------------------------------------------------------------------------
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] READ_CMD    = CMD_READ,
    parameter int         AW          = 24
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          spi_sck,
    input  logic          spi_ss,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          underrun,
    output logic          busy
);

    logic sck_rise;
    logic sck_fall;
    logic ss_rise;
    logic ss_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clock  (clock),
        .resetn (resetn),
        .d_i    (spi_sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clock  (clock),
        .resetn (resetn),
        .d_i    (spi_ss),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    // mosi gets one stage more than the edge detectors have before their
    // output flop, so the bit seen with a rise pulse is the one sampled at
    // the same clock edge that first saw sck high.
    logic [SYNC_STAGES:0] mosi_sync_q;
    logic                 mosi_bit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) mosi_sync_q <= '0;
        else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], spi_mosi};
    end

    assign mosi_bit = mosi_sync_q[SYNC_STAGES];

    // ------------------------------------------------------------------ state
    logic [2:0]    state_q,      state_d;
    bit_cnt_t      bit_cnt_q,    bit_cnt_d;
    logic [AW-1:0] shift_q,      shift_d;
    logic          first_word_q, first_word_d;
    logic [31:0]   tx_q,         tx_d;
    logic          miso_q,       miso_d;
    logic          req_q,        req_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [AW-1:0] next_addr_q,  next_addr_d;
    logic          pend_q,       pend_d;     // a word fetch is wanted
    logic          drop_q,       drop_d;     // outstanding fetch belongs to a dead transfer
    logic [31:0]   buf_q,        buf_d;      // one-entry prefetch buffer
    logic          buf_valid_q,  buf_valid_d;
    logic          underrun_q,   underrun_d;
`ifdef FAST_READ_EN
    logic          fast_q,       fast_d;
    logic [1:0]    byte_off_q,   byte_off_d;
`endif

    logic [7:0]    rx_byte;
    logic [AW-1:0] rx_addr;
    logic          word_start;
    logic [31:0]   load_word;
    logic [31:0]   cur_word;
    logic          ack_fill;

    always_comb begin
        // NOTE: every variable gets its default here first; a path that left
        // one unassigned would infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        first_word_d = first_word_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        req_d        = req_q;
        mem_addr_d   = mem_addr_q;
        next_addr_d  = next_addr_q;
        pend_d       = pend_q;
        drop_d       = drop_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        underrun_d   = underrun_q;
`ifdef FAST_READ_EN
        fast_d       = fast_q;
        byte_off_d   = byte_off_q;
`endif

        rx_byte    = {shift_q[6:0], mosi_bit};
        rx_addr    = {shift_q[AW-2:0], mosi_bit};
        // The first word may begin mid-word (unaligned start address).
        word_start = first_word_q || (bit_cnt_q == '0);
        load_word  = buf_valid_q ? buf_q : 32'hFFFF_FFFF;
        cur_word   = word_start ? load_word : tx_q;
        ack_fill   = req_q && mem_ack && !drop_q;

        // Memory handshake completion
        if (req_q && mem_ack) begin
            req_d  = 1'b0;
            drop_d = 1'b0;
        end
        if (ack_fill) begin
            buf_d       = mem_rdata;
            buf_valid_d = 1'b1;
        end

        // Launch a fetch only into an empty buffer with nothing in flight;
        // checking req_q also guarantees req is low for a cycle after ack.
        if (pend_q && !req_q && !buf_valid_q && !ss_rise) begin
            req_d       = 1'b1;
            mem_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + AW'(4);
            pend_d      = 1'b0;
        end

        if (ss_rise) begin
            // End of transfer beats any sck edge seen in the same cycle.
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            miso_d      = 1'b1;
            pend_d      = 1'b0;
            buf_valid_d = 1'b0;
            if (req_q && !mem_ack) drop_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
`ifdef FAST_READ_EN
                        fast_d    = 1'b0;
`endif
                    end
                end

                ST_CMD: begin
                    if (sck_rise) begin
                        shift_d   = rx_addr;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == bit_cnt_t'(7)) begin
                            bit_cnt_d = '0;
                            if (rx_byte == READ_CMD) begin
                                state_d = ST_ADDR;
                            end
`ifdef FAST_READ_EN
                            else if (rx_byte == CMD_FAST_READ) begin
                                state_d = ST_ADDR;
                                fast_d  = 1'b1;
                            end
`endif
                            else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_ADDR: begin
                    if (sck_rise) begin
                        shift_d   = rx_addr;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == bit_cnt_t'(AW - 1)) begin
                            next_addr_d  = {rx_addr[AW-1:2], 2'b00};
                            pend_d       = 1'b1;
                            first_word_d = 1'b1;
                            // Start the first word at the addressed byte.
                            bit_cnt_d    = {rx_addr[1:0], 3'b000};
                            state_d      = ST_DATA;
`ifdef FAST_READ_EN
                            byte_off_d   = rx_addr[1:0];
                            if (fast_q) begin
                                bit_cnt_d = '0;
                                state_d   = ST_DUMMY;
                            end
`endif
                        end
                    end
                end

`ifdef FAST_READ_EN
                ST_DUMMY: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == bit_cnt_t'(7)) begin
                            bit_cnt_d = {byte_off_q, 3'b000};
                            state_d   = ST_DATA;
                        end
                    end
                end
`endif

                ST_DATA: begin
                    if (sck_fall) begin
                        miso_d       = word_bit(cur_word, bit_cnt_q);
                        bit_cnt_d    = bit_cnt_q + 1'b1;
                        first_word_d = 1'b0;
                        if (word_start) begin
                            tx_d        = load_word;
                            // A same-cycle ack refills the buffer for the next word.
                            buf_valid_d = ack_fill;
                            pend_d      = 1'b1;
                            if (!buf_valid_q) underrun_d = 1'b1;
                        end
                    end
                end

                ST_IGNORE: begin
                    miso_d = 1'b1;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            first_word_q <= 1'b0;
            tx_q         <= '0;
            miso_q       <= 1'b1;
            req_q        <= 1'b0;
            mem_addr_q   <= '0;
            next_addr_q  <= '0;
            pend_q       <= 1'b0;
            drop_q       <= 1'b0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef FAST_READ_EN
            fast_q       <= 1'b0;
            byte_off_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            first_word_q <= first_word_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            req_q        <= req_d;
            mem_addr_q   <= mem_addr_d;
            next_addr_q  <= next_addr_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            underrun_q   <= underrun_d;
`ifdef FAST_READ_EN
            fast_q       <= fast_d;
            byte_off_q   <= byte_off_d;
`endif
        end
    end

    assign spi_miso = miso_q;
    assign mem_req  = req_q;
    assign mem_addr = mem_addr_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_responder
//   Directed bench: acts as a mode-0 SPI master (sck period 16 clocks) and as
//   the backing memory with a programmable ack delay. Expected words come from
//   the bench's own memory table.
// -----------------------------------------------------------------------------
module tb_spi_flash_responder;

    localparam int H = 8;  // clocks per sck half period

    logic        clock = 1'b0;
    logic        resetn;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        underrun;
    logic        busy;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          ack_delay = 2;
    int          req_count = 0;
    logic [23:0] addr_log [0:63];

    always #5 clock = ~clock;

    spi_flash_responder dut (
        .clock     (clock),
        .resetn    (resetn),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .underrun  (underrun),
        .busy      (busy)
    );

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        case (a)
            24'h000000: return 32'h1234_5678;
            24'h000010: return 32'hDEAD_BEEF;
            24'h000014: return 32'h1122_3344;
            24'h000018: return 32'h5566_7788;
            24'h000020: return 32'hCAFE_F00D;
            24'hFFFFFC: return 32'h0BAD_F00D;
            default:    return {8'hA5, a};
        endcase
    endfunction

    // Backing memory: log each request, ack after ack_delay cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (mem_req === 1'b1) begin
                if (req_count < 64) addr_log[req_count] = mem_addr;
                req_count++;
                repeat (ack_delay - 1) @(negedge clock);
                mem_rdata = mem_word(mem_addr);
                mem_ack   = 1'b1;
                @(negedge clock);
                mem_ack   = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One mode-0 bit: falling edge + mosi change, sample miso, rising edge.
    task automatic spi_bit(input logic mo, output logic mi);
        spi_sck  = 1'b0;
        spi_mosi = mo;
        wait_clks(H);
        mi       = spi_miso;
        spi_sck  = 1'b1;
        wait_clks(H);
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits);
        logic mi;
        for (int i = nbits - 1; i >= 0; i--) spi_bit(val[i], mi);
    endtask

    task automatic recv_bits(input int nbits, output logic [31:0] w);
        logic mi;
        w = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(1'b0, mi);
            w = {w[30:0], mi};
        end
    endtask

    task automatic start_read(input logic [7:0] op, input logic [23:0] a);
        spi_ss = 1'b0;
        wait_clks(H);
        send_bits({24'd0, op}, 8);
        send_bits({8'd0, a}, 24);
    endtask

    // sck low and ss high together: the simultaneous fall must be ignored.
    task automatic spi_end();
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        wait_clks(48);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int          base;

        resetn   = 1'b0;
        spi_sck  = 1'b0;
        spi_ss   = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(4);
        check("rst_miso",     32'(spi_miso), 32'h1);
        check("rst_req",      32'(mem_req),  32'h0);
        check("rst_addr",     32'(mem_addr), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        resetn = 1'b1;
        wait_clks(8);

        // 1: plain read of one word at 0x10
        base = req_count;
        start_read(8'h03, 24'h000010);
        check("t1_busy", 32'(busy), 32'h1);
        recv_bits(32, w);
        check("t1_word",     w,                     32'hDEAD_BEEF);
        check("t1_addr",     32'(addr_log[base]),   32'h10);
        check("t1_underrun", 32'(underrun),         32'h0);
        spi_end();
        check("t1_idle_busy", 32'(busy),     32'h0);
        check("t1_idle_miso", 32'(spi_miso), 32'h1);

        // 2: three consecutive words
        base = req_count;
        start_read(8'h03, 24'h000010);
        recv_bits(32, w);
        check("t2_word0", w, 32'hDEAD_BEEF);
        recv_bits(32, w);
        check("t2_word1", w, 32'h1122_3344);
        check("t2_reqs_for_3_words", 32'(req_count - base), 32'd3);
        recv_bits(32, w);
        check("t2_word2", w, 32'h5566_7788);
        check("t2_addr1", 32'(addr_log[base + 1]), 32'h14);
        check("t2_addr2", 32'(addr_log[base + 2]), 32'h18);
        // word 2's first fall prefetches the next word
        check("t2_prefetch", 32'(addr_log[base + 3]), 32'h1C);
        spi_end();

        // 3: unknown opcode
        base = req_count;
        spi_ss = 1'b0;
        wait_clks(H);
        send_bits(32'h9F, 8);
        recv_bits(32, w);
        check("t3_miso_ones", w,                        32'hFFFF_FFFF);
        check("t3_no_req",    32'(req_count - base),    32'd0);
        check("t3_busy",      32'(busy),                32'h1);
        spi_end();
        check("t3_busy_after", 32'(busy), 32'h0);

        // unaligned start: first word begins at byte 2
        base = req_count;
        start_read(8'h03, 24'h000012);
        recv_bits(16, w);
        check("off_first_half", w, 32'h0000_BEEF);
        check("off_addr", 32'(addr_log[base]), 32'h10);
        recv_bits(32, w);
        check("off_next_word", w, 32'h1122_3344);
        spi_end();

        // 5: address wrap
        base = req_count;
        start_read(8'h03, 24'hFFFFFC);
        recv_bits(32, w);
        check("t5_word0", w, 32'h0BAD_F00D);
        recv_bits(32, w);
        check("t5_word1", w, 32'h1234_5678);
        check("t5_wrap_addr", 32'(addr_log[base + 1]), 32'h0);
        spi_end();

        // 6: abort mid-address, then a clean transaction
        base = req_count;
        spi_ss = 1'b0;
        wait_clks(H);
        send_bits(32'h03, 8);
        send_bits(32'h0, 20);
        spi_end();
        check("t6_abort_no_req", 32'(req_count - base), 32'd0);
        base = req_count;
        start_read(8'h03, 24'h000020);
        recv_bits(32, w);
        check("t6_word", w, 32'hCAFE_F00D);
        check("t6_addr", 32'(addr_log[base]), 32'h20);
        spi_end();

        // 7: fast read
        base = req_count;
        start_read(8'h0B, 24'h000000);
        send_bits(32'h0, 8);
        recv_bits(32, w);
`ifdef FAST_READ_EN
        check("t7_fast_word", w, 32'h1234_5678);
        check("t7_fast_addr", 32'(addr_log[base]), 32'h0);
`else
        check("t7_fast_rejected", w, 32'hFFFF_FFFF);
        check("t7_no_req", 32'(req_count - base), 32'd0);
`endif
        spi_end();

        // 4: late memory -> FF word, underrun, late data moves to next word
        ack_delay = 30;
        start_read(8'h03, 24'h000010);
        recv_bits(32, w);
        check("t4_ff_word",  w,             32'hFFFF_FFFF);
        check("t4_underrun", 32'(underrun), 32'h1);
        recv_bits(32, w);
        check("t4_late_word", w, 32'hDEAD_BEEF);
        spi_end();
        ack_delay = 2;

        // 8: asynchronous reset during DATA
        start_read(8'h03, 24'h000010);
        recv_bits(8, w);
        @(negedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("t8_miso",     32'(spi_miso), 32'h1);
        check("t8_req",      32'(mem_req),  32'h0);
        check("t8_underrun", 32'(underrun), 32'h0);
        check("t8_busy",     32'(busy),     32'h0);
        spi_sck = 1'b0;
        spi_ss  = 1'b1;
        wait_clks(40);
        resetn = 1'b1;
        wait_clks(8);

        // recovery after reset
        start_read(8'h03, 24'h000014);
        recv_bits(32, w);
        check("t8_recover_word", w, 32'h1122_3344);
        spi_end();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
